mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Target/responder end of the 16-bit m_* memory bus driven by the CPU/MCGA memory arbiter.
//  Accepts a granted request (access/addr/wr_en/bytesel/data), services it from an internal
//  word RAM after programmable wait states, returns a one-cycle ack with read data.
//  Used as on-chip video/scratch memory and as a bus-level SDRAM stand-in for simulation.
// PARAMETERS
//  MEM_WORDS    16384   RAM depth in 16-bit words, power of 2, 2..262144
//  BASE_ADDR    20'h0   byte base of decoded window, aligned to MEM_WORDS*2
//  WAIT_STATES  1       extra cycles inserted before RAM access, 0..15
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  s_addr       in   19  word address [19:1]
//  s_data_in    in   16  write data from initiator
//  s_data_out   out  16  read data, registered
//  s_access     in   1   request valid, held by initiator until ack
//  s_ack        out  1   one-cycle completion pulse, registered
//  s_wr_en      in   1   1=write, 0=read
//  s_bytesel    in   2   [0]=low byte, [1]=high byte enable (writes)
//  busy         out  1   high in every state except IDLE
//  rd_count     out  32  completed reads (only with MEM_RESP_STATS_EN)
//  wr_count     out  32  completed writes (only with MEM_RESP_STATS_EN)
// BEHAVIOUR
//  Reset: state=IDLE, s_ack=0, s_data_out=16'h0000, busy=0, counters=0; RAM contents not cleared.
//  FSM: IDLE -> WAIT -> MEM -> ACK -> TURN -> IDLE.
//   IDLE: s_access=1 at edge -> latch addr/wr_en/bytesel/data; go WAIT (MEM if WAIT_STATES=0).
//   WAIT: 4-bit counter, stays exactly WAIT_STATES cycles.
//   MEM: one RAM op on latched request; write uses byte enables; read registers RAM word.
//   ACK: s_ack=1 exactly one cycle; s_data_out valid in same cycle.
//   TURN: one cycle; s_access ignored, so a master dropping access the cycle after ack
//         never causes a duplicate transaction.
//  Latency: s_ack high WAIT_STATES+2 cycles after the edge that sampled s_access in IDLE.
//   Back-to-back issue interval: WAIT_STATES+4 cycles.
//  Decode: in_range = s_addr[19:IDX+1]==BASE_ADDR[19:IDX+1], IDX=$clog2(MEM_WORDS);
//   RAM index = s_addr[IDX:1].
//   Out-of-range: still acked with same timing (no bus hang); read returns 16'hFFFF;
//   write discarded.
//  Writes: s_data_out unchanged; bytesel=2'b00 write acked, RAM untouched.
//  Read data held in s_data_out until next read completes.
//  Inputs sampled only in IDLE; changes to addr/data/wr_en while busy ignored.
//  s_access dropped mid-transaction: transaction still completes and acks.
//  Reset mid-transaction: abort to IDLE next edge; no ack; pending write lost
//   unless already committed in MEM.
// CONFIGURATION
//  MEM_RESP_STATS_EN defined: rd_count/wr_count ports exist; each increments in the ACK cycle
//   of a completed in-range read/write, 32-bit wrap-around, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package mem_resp_pkg: state enum {IDLE,WAIT,MEM,ACK,TURN}, 3-bit encoding;
//   OOR_READ_DATA=16'hFFFF; WS_W=4.
//  Sub-module mem_resp_ram: single-port synchronous RAM, MEM_WORDS x 16, 2 byte-write enables,
//   registered read; inferable as block RAM.
//  Top holds FSM, request latch, decode, wait counter, output registers, optional stats.
// TESTING
//  1. WAIT_STATES=1: write 16'hBEEF @word 0x00010 bytesel=11; read back -> ack 3 cycles
//     after sample; data=BEEF.
//  2. Write 16'h1234 then 16'hAB00 bytesel=10 to same addr; read -> 16'hAB34.
//  3. Read s_addr outside window -> ack at normal latency, s_data_out=16'hFFFF;
//     out-of-range write leaves RAM unchanged.
//  4. s_access held high continuously -> exactly one ack per WAIT_STATES+4 cycles;
//     no duplicate write.
//  5. Assert reset during WAIT -> no ack; s_ack=0, busy=0, s_data_out=0 next cycle;
//     next request serviced normally.
//  6. MEM_RESP_STATS_EN: 3 reads + 2 writes in range, 1 out-of-range -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the m_* bus responder.
package mem_resp_pkg;

    localparam int WS_W = 4;
    localparam logic [15:0] OOR_READ_DATA = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        MEM  = 3'd2,
        ACK  = 3'd3,
        TURN = 3'd4
    } state_e;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module mem_resp_ram #(
    parameter int MEM_WORDS = 16384,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [MEM_WORDS];
    logic [15:0] rdata_q;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (be[0]) begin
                    mem[addr][7:0] <= wdata[7:0];
                end
                if (be[1]) begin
                    mem[addr][15:8] <= wdata[15:8];
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the 16-bit m_* memory bus: wait states, word RAM, one-cycle ack.
// Optional MEM_RESP_STATS_EN adds rd_count/wr_count completion counters.
module mem_bus_responder
    import mem_resp_pkg::*;
#(
    parameter int          MEM_WORDS   = 16384,
    parameter logic [19:0] BASE_ADDR   = 20'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] s_addr,
    input  logic [15:0] s_data_in,
    output logic [15:0] s_data_out,
    input  logic        s_access,
    output logic        s_ack,
    input  logic        s_wr_en,
    input  logic [1:0]  s_bytesel,
    output logic        busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int IDX = $clog2(MEM_WORDS);
    localparam logic [WS_W-1:0] WS_CNT = WS_W'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [WS_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [19:1]       req_addr_q, req_addr_d;
    logic [15:0]       req_data_q, req_data_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_be_q, req_be_d;
    logic              s_ack_q, s_ack_d;
    logic              busy_q, busy_d;
    logic [15:0]       s_data_out_q, s_data_out_d;
    logic              cur_in_range;
    logic              req_in_range;
    logic              ram_en;
    logic [15:0]       ram_rdata;

    // FSM, request latch and wait counter next-state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_wr_d   = req_wr_q;
        req_be_d   = req_be_q;
        case (state_q)
            IDLE: begin
                if (s_access) begin
                    req_addr_d = s_addr;
                    req_data_d = s_data_in;
                    req_wr_d   = s_wr_en;
                    req_be_d   = s_bytesel;
                    if (WS_CNT == 4'd0) begin
                        state_d = MEM;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WS_CNT - 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = MEM;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            MEM:     state_d = ACK;
            ACK:     state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM is clocked on entry to MEM so its registered read word is ready inside MEM;
    // req_*_d already carries the live request when MEM follows IDLE directly.
    assign cur_in_range = (req_addr_d[19:IDX+1] == BASE_ADDR[19:IDX+1]);
    assign req_in_range = (req_addr_q[19:IDX+1] == BASE_ADDR[19:IDX+1]);
    assign ram_en       = (state_d == MEM) && !reset && cur_in_range;

    mem_resp_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (IDX)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (req_wr_d),
        .be    (req_be_d),
        .addr  (req_addr_d[IDX:1]),
        .wdata (req_data_d),
        .rdata (ram_rdata)
    );

    // Registered bus outputs.
    always_comb begin
        s_ack_d = (state_d == ACK);
        busy_d  = (state_d != IDLE);
        if ((state_q == MEM) && !req_wr_q) begin
            s_data_out_d = req_in_range ? ram_rdata : OOR_READ_DATA;
        end else begin
            s_data_out_d = s_data_out_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            req_addr_q   <= 19'd0;
            req_data_q   <= 16'h0000;
            req_wr_q     <= 1'b0;
            req_be_q     <= 2'b00;
            s_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            s_data_out_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_wr_q     <= req_wr_d;
            req_be_q     <= req_be_d;
            s_ack_q      <= s_ack_d;
            busy_q       <= busy_d;
            s_data_out_q <= s_data_out_d;
        end
    end

    assign s_ack      = s_ack_q;
    assign busy       = busy_q;
    assign s_data_out = s_data_out_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Counters step on the MEM->ACK edge so the new value is visible during ACK.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if ((state_q == MEM) && req_in_range) begin
            if (req_wr_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Completion counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: vector table, corner sequences, random vs model.
module tb_mem_bus_responder;

    localparam int          WS   = 1;
    localparam int          MW   = 16384;
    localparam logic [19:0] BASE = 20'h40000;
    localparam logic [18:0] WB   = 19'h20000;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:1] s_addr;
    logic [15:0] s_data_in;
    logic [15:0] s_data_out;
    logic        s_access;
    logic        s_ack;
    logic        s_wr_en;
    logic [1:0]  s_bytesel;
    logic        busy;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    mem_bus_responder #(
        .MEM_WORDS   (MW),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_addr     (s_addr),
        .s_data_in  (s_data_in),
        .s_data_out (s_data_out),
        .s_access   (s_access),
        .s_ack      (s_ack),
        .s_wr_en    (s_wr_en),
        .s_bytesel  (s_bytesel),
        .busy       (busy)
`ifdef MEM_RESP_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt[15];
    logic [18:0] pool[8];
    logic [15:0] mdl[8];
    logic [15:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [18:0] a);
        return (int'(a) / MW) == (int'(BASE) / (2 * MW));
    endfunction

    // One bus transaction, started at a negedge with the DUT idle; ends two cycles after ack.
    task automatic txn(input logic wr, input logic [18:0] addr, input logic [15:0] data,
                       input logic [1:0] be, input bit hold, input logic [15:0] exp_out,
                       input string tag);
        int lat;
        lat = -1;
        s_access  = 1'b1;
        s_wr_en   = wr;
        s_addr    = addr;
        s_data_in = data;
        s_bytesel = be;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                s_data_in = ~data;
                s_addr    = addr ^ 19'h00001;
                s_wr_en   = ~wr;
                s_bytesel = ~be;
                if (!hold) s_access = 1'b0;
            end
            if (s_ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, WS + 2);
        check({tag, " data_out"}, s_data_out, exp_out);
        check({tag, " busy_in_ack"}, busy, 1'b1);
        if (lat > 0 && in_window(addr)) begin
            if (wr) exp_wr_cnt++;
            else    exp_rd_cnt++;
        end
`ifdef MEM_RESP_STATS_EN
        check({tag, " rd_count"}, rd_count, exp_rd_cnt);
        check({tag, " wr_count"}, wr_count, exp_wr_cnt);
`endif
        s_access = 1'b0;
        @(negedge clk);
        check({tag, " ack_one_cycle"}, s_ack, 1'b0);
        @(negedge clk);
        check({tag, " idle_after"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_access = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_rd = 16'h0000;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
    endtask

    initial begin
        int acks;
        int first_ack;
        int prev_ack;
        logic        wr;
        logic [18:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        int          k;
        bit          oor;

        reset = 1'b1; s_access = 1'b0; s_wr_en = 1'b0;
        s_addr = 19'd0; s_data_in = 16'h0000; s_bytesel = 2'b00;
        repeat (3) @(negedge clk);
        check("reset ack", s_ack, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset data_out", s_data_out, 16'h0000);
        do_reset();

        vt[0]  = '{1'b1, WB + 19'h10,   16'hBEEF, 2'b11, 16'h0000};
        vt[1]  = '{1'b0, WB + 19'h10,   16'h0000, 2'b11, 16'hBEEF};
        vt[2]  = '{1'b1, WB + 19'h20,   16'h1234, 2'b11, 16'hBEEF};
        vt[3]  = '{1'b1, WB + 19'h20,   16'hAB00, 2'b10, 16'hBEEF};
        vt[4]  = '{1'b0, WB + 19'h20,   16'h0000, 2'b11, 16'hAB34};
        vt[5]  = '{1'b0, 19'h00010,     16'h0000, 2'b11, 16'hFFFF};
        vt[6]  = '{1'b1, 19'h00020,     16'h5555, 2'b11, 16'hFFFF};
        vt[7]  = '{1'b0, WB + 19'h20,   16'h0000, 2'b11, 16'hAB34};
        vt[8]  = '{1'b1, WB + 19'h20,   16'h9999, 2'b00, 16'hAB34};
        vt[9]  = '{1'b0, WB + 19'h20,   16'h0000, 2'b11, 16'hAB34};
        vt[10] = '{1'b1, WB + 19'h10,   16'h1177, 2'b01, 16'hAB34};
        vt[11] = '{1'b0, WB + 19'h10,   16'h0000, 2'b11, 16'hBE77};
        vt[12] = '{1'b0, 19'h24010,     16'h0000, 2'b11, 16'hFFFF};
        vt[13] = '{1'b1, WB + 19'h3FFF, 16'hC3C3, 2'b11, 16'hFFFF};
        vt[14] = '{1'b0, WB + 19'h3FFF, 16'h0000, 2'b11, 16'hC3C3};
        for (int i = 0; i < 15; i++) begin
            txn(vt[i].wr, vt[i].addr, vt[i].data, vt[i].be, (i % 2) == 0, vt[i].exp,
                $sformatf("vec%0d", i));
        end
        last_rd = 16'hC3C3;

        // Access held high throughout: one ack every WS+4 cycles.
        s_access = 1'b1; s_wr_en = 1'b1; s_addr = WB + 19'h40;
        s_data_in = 16'h00AA; s_bytesel = 2'b11;
        acks = 0; first_ack = -1; prev_ack = -1;
        for (int n = 1; n <= 3 * (WS + 4); n++) begin
            @(negedge clk);
            if (s_ack === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = n;
                else check("held spacing", n - prev_ack, WS + 4);
                prev_ack = n;
            end
        end
        check("held ack count", acks, 3);
        check("held first ack", first_ack, WS + 2);
        s_access = 1'b0;
        exp_wr_cnt += acks;
        repeat (2) @(negedge clk);
        check("held idle", busy, 1'b0);

        // Master keeps access through TURN with new data: no second transaction.
        s_access = 1'b1; s_data_in = 16'h1357;
        acks = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (s_ack === 1'b1) begin
                acks++;
                s_data_in = 16'hDEAD;
            end
            if (n == WS + 4) s_access = 1'b0;
        end
        check("turn ack count", acks, 1);
        exp_wr_cnt += acks;
        txn(1'b0, WB + 19'h40, 16'h0000, 2'b11, 1'b1, 16'h1357, "turn readback");

        // Reset during WAIT aborts the pending write.
        txn(1'b1, WB + 19'h50, 16'h1111, 2'b11, 1'b1, 16'h1357, "pre_reset wr");
        s_access = 1'b1; s_wr_en = 1'b1; s_addr = WB + 19'h50;
        s_data_in = 16'h7777; s_bytesel = 2'b11;
        @(negedge clk);
        check("wait busy", busy, 1'b1);
        reset = 1'b1; s_access = 1'b0;
        @(negedge clk);
        check("abort ack", s_ack, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort data_out", s_data_out, 16'h0000);
        reset = 1'b0;
        last_rd = 16'h0000; exp_rd_cnt = 0; exp_wr_cnt = 0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_ack === 1'b1) acks++;
        end
        check("abort no ack", acks, 0);
        txn(1'b0, WB + 19'h50, 16'h0000, 2'b11, 1'b0, 16'h1111, "post_reset rd");
        last_rd = 16'h1111;

        // Random traffic against an array model of a few pool words.
        for (int i = 0; i < 8; i++) begin
            pool[i] = WB + 19'(i * 1237 + 5);
            mdl[i]  = 16'($urandom);
            txn(1'b1, pool[i], mdl[i], 2'b11, 1'b1, last_rd, "rnd init");
        end
        for (int i = 0; i < 60; i++) begin
            wr  = 1'($urandom);
            be  = 2'($urandom);
            d   = 16'($urandom);
            k   = $urandom_range(0, 7);
            oor = ($urandom_range(0, 3) == 0);
            if (oor) begin
                if ($urandom_range(0, 1) == 0) a = 19'($urandom_range(0, 32'h1FFFF));
                else                          a = 19'($urandom_range(32'h24000, 32'h7FFFF));
            end else begin
                a = pool[k];
            end
            if (!wr) begin
                last_rd = oor ? 16'hFFFF : mdl[k];
            end else if (!oor) begin
                mdl[k] = ((be[1] ? d : mdl[k]) & 16'hFF00) | ((be[0] ? d : mdl[k]) & 16'h00FF);
            end
            txn(wr, a, d, be, 1'($urandom), last_rd, $sformatf("rnd%0d", i));
        end

        // Stats scenario: 3 reads + 2 writes in range, 1 out-of-range.
        do_reset();
        txn(1'b0, pool[0], 16'h0000, 2'b11, 1'b1, mdl[0], "st rd0");
        txn(1'b1, pool[1], 16'h2468, 2'b11, 1'b1, mdl[0], "st wr1");
        txn(1'b0, pool[1], 16'h0000, 2'b11, 1'b0, 16'h2468, "st rd1");
        txn(1'b0, 19'h00777, 16'h0000, 2'b11, 1'b1, 16'hFFFF, "st oor");
        txn(1'b1, pool[2], 16'h8642, 2'b11, 1'b0, 16'hFFFF, "st wr2");
        txn(1'b0, pool[2], 16'h0000, 2'b11, 1'b1, 16'h8642, "st rd2");
`ifdef MEM_RESP_STATS_EN
        check("stats rd_count", rd_count, 3);
        check("stats wr_count", wr_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
